// File: rtl/rst_seq_ctrl_pkg.sv
// Shared state encodings, default timing constants and counter-width helper for the reset sequencer.
// Consumed by rst_seq_ctrl and rst_seq_ctrl_timer (optional ack gating: RST_SEQ_ACK_EN).
package rst_seq_ctrl_pkg;

    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_REL      = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int DEF_NUM_DOM   = 3;
    localparam int DEF_HOLD_CYC  = 16;
    localparam int DEF_DELAY_CYC = 8;

    // Wide enough to hold the larger of the two limits itself, not just limit-1.
    function automatic int cnt_width(input int hold_cyc, input int delay_cyc);
        return $clog2(((hold_cyc > delay_cyc) ? hold_cyc : delay_cyc) + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_timer.sv
// Shared hold/spacing timer: up-counter with synchronous clear and terminal-count flag (cnt == limit-1).
// The limit is chosen by the sequencer FSM per state.
module rst_seq_ctrl_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every domain reset, then releases domains 0..NUM_DOM-1 with fixed spacing.
// Build option RST_SEQ_ACK_EN adds i_dom_ack; each next release then waits for the previous domain's ack.
//   state       | meaning
//   ST_HOLD     | all resets asserted, timing the initial hold
//   ST_REL      | timing the spacing before releasing domain r_idx
//   ST_WAIT_ACK | domain r_idx released, waiting for its ack (ack build only)
//   ST_DONE     | all domains released, waiting for a software reset request
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int NUM_DOM   = DEF_NUM_DOM,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int DELAY_CYC = DEF_DELAY_CYC
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sw_rst_req,
`ifdef RST_SEQ_ACK_EN
    input  logic [NUM_DOM-1:0] i_dom_ack,
`endif
    output logic [NUM_DOM-1:0] o_rst_out,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CNT_W = cnt_width(HOLD_CYC, DELAY_CYC);
    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(DELAY_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOM - 1);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_DOM-1:0] r_rst_out;
    logic               r_busy;
    logic               r_done;

    logic [NUM_DOM-1:0] w_dom_mask;
    logic [CNT_W-1:0]   w_limit;
    logic               w_is_cnt;
    logic               w_clr;
    logic               w_tc;

    assign w_dom_mask = NUM_DOM'(1) << r_idx;
    assign w_limit    = (r_state == ST_HOLD) ? HOLD_LIM : DELAY_LIM;
    assign w_is_cnt   = (r_state == ST_HOLD) || (r_state == ST_REL);
    // Timer is parked at zero outside HOLD/REL so every timed phase starts from a clean count.
    assign w_clr      = i_sw_rst_req || w_tc || !w_is_cnt;

`ifdef RST_SEQ_ACK_EN
    logic w_ack;
    assign w_ack = |(i_dom_ack & w_dom_mask);
`endif

    rst_seq_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_clr),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_HOLD;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (!i_sw_rst_req && w_tc) begin
                        r_state <= ST_REL;
                        r_idx   <= '0;
                    end
                end
                ST_REL: begin
                    if (i_sw_rst_req) begin
                        r_state   <= ST_HOLD;
                        r_idx     <= '0;
                        r_rst_out <= '1;
                    end else if (w_tc) begin
                        r_rst_out <= r_rst_out & ~w_dom_mask;
`ifdef RST_SEQ_ACK_EN
                        r_state   <= ST_WAIT_ACK;
`else
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
`endif
                    end
                end
                ST_WAIT_ACK: begin
`ifdef RST_SEQ_ACK_EN
                    if (i_sw_rst_req) begin
                        r_state   <= ST_HOLD;
                        r_idx     <= '0;
                        r_rst_out <= '1;
                    end else if (w_ack) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_REL;
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end
`else
                    // Unreachable without acks; recover into a fresh, fully asserted hold.
                    r_state   <= ST_HOLD;
                    r_idx     <= '0;
                    r_rst_out <= '1;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
`endif
                end
                ST_DONE: begin
                    if (i_sw_rst_req) begin
                        r_state   <= ST_HOLD;
                        r_idx     <= '0;
                        r_rst_out <= '1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_HOLD;
                    r_idx     <= '0;
                    r_rst_out <= '1;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign o_rst_out = r_rst_out;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: release schedule derived from edge offsets relative to the last restart edge.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

    localparam int N = 3;
    localparam int H = 4;
    localparam int D = 3;
`ifdef RST_SEQ_ACK_EN
    localparam int ACK_LAT = 1;
`else
    localparam int ACK_LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         sw  = 1'b0;
    logic [N-1:0] ro;
    logic         busy, done;

    logic         rst2 = 1'b1;
    logic         sw2  = 1'b0;
    logic [0:0]   ro2;
    logic         busy2, done2;

`ifdef RST_SEQ_ACK_EN
    logic [N-1:0] ack  = '0;
    logic [0:0]   ack2 = 1'b1;
`endif

    rst_seq_ctrl #(.NUM_DOM(N), .HOLD_CYC(H), .DELAY_CYC(D)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sw_rst_req (sw),
`ifdef RST_SEQ_ACK_EN
        .i_dom_ack    (ack),
`endif
        .o_rst_out    (ro),
        .o_busy       (busy),
        .o_done       (done)
    );

    rst_seq_ctrl #(.NUM_DOM(1), .HOLD_CYC(1), .DELAY_CYC(1)) u_dut_min (
        .i_clk        (clk),
        .i_rst        (rst2),
        .i_sw_rst_req (sw2),
`ifdef RST_SEQ_ACK_EN
        .i_dom_ack    (ack2),
`endif
        .o_rst_out    (ro2),
        .o_busy       (busy2),
        .o_done       (done2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] sb_q[$];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: rst_out/busy/done got %b required %b", name, act, exp);
        end
    endtask

    // Expected {rst_out, busy, done} d edges after the sequence (re)started.
    function automatic logic [4:0] expect_at(input int d);
        logic [N-1:0] e_ro;
        logic         e_done;
        for (int i = 0; i < N; i++) e_ro[i] = (d < H + (i + 1) * D);
        e_done = (d >= H + N * D);
        return {e_ro, !e_done, e_done};
    endfunction

    typedef struct {
        string name;
        bit    por;
        int    ev_first;
        int    ev_last;
        bit    ev_rst;
        int    ncyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"por",      1'b1, 0,  0,  1'b0, 16};
        vecs[1] = '{"sw_done",  1'b0, 1,  1,  1'b0, 16};
        vecs[2] = '{"sw_rel",   1'b1, 10, 10, 1'b0, 25};
        vecs[3] = '{"sw_hold",  1'b1, 3,  3,  1'b0, 17};
        vecs[4] = '{"sw_held",  1'b0, 1,  6,  1'b0, 21};
        vecs[5] = '{"rst_mid",  1'b1, 9,  9,  1'b1, 24};

`ifndef RST_SEQ_ACK_EN
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].por) begin
                rst = 1'b1;
                sw  = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check({vecs[v].name, "_reset"}, {ro, busy, done}, {3'b111, 1'b1, 1'b0});
                rst = 1'b0;
            end
            for (int k = 1; k <= vecs[v].ncyc; k++) begin
                bit ev;
                int o;
                ev = (vecs[v].ev_first > 0) && (k >= vecs[v].ev_first) && (k <= vecs[v].ev_last);
                if (vecs[v].ev_rst) rst = ev;
                else                sw  = ev;
                o = 0;
                if (vecs[v].ev_first > 0 && k >= vecs[v].ev_first)
                    o = (k < vecs[v].ev_last) ? k : vecs[v].ev_last;
                sb_q.push_back(expect_at(k - o));
                @(posedge clk);
                #1;
                check($sformatf("%s_k%0d", vecs[v].name, k), {ro, busy, done}, sb_q.pop_front());
            end
            rst = 1'b0;
            sw  = 1'b0;
        end
`else
        // Ack build: domain 0 released at 7, then stall until ack[0]; ack[1] is high early while domain 1 is still held.
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("ack_reset", {ro, busy, done}, {3'b111, 1'b1, 1'b0});
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            logic [N-1:0] e_ro;
            bit           e_done;
            ack = (k >= 37) ? 3'b111 : (k >= 28) ? 3'b011 : 3'b000;
            e_ro[0] = (k < 7);
            e_ro[1] = (k < 31);
            e_ro[2] = (k < 35);
            e_done  = (k >= 37);
            sb_q.push_back({e_ro, !e_done, e_done});
            @(posedge clk);
            #1;
            check($sformatf("ack_k%0d", k), {ro, busy, done}, sb_q.pop_front());
        end
`endif

        // Minimal configuration, reset re-asserted in the cycle domain 0 would have released.
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("min_reset", {2'b00, ro2, busy2, done2}, 5'b00110);
        rst2 = 1'b0;
        @(posedge clk); #1;
        check("min_k1", {2'b00, ro2, busy2, done2}, 5'b00110);
        rst2 = 1'b1;
        @(posedge clk); #1;
        check("min_rst_mid", {2'b00, ro2, busy2, done2}, 5'b00110);
        rst2 = 1'b0;
        @(posedge clk); #1;
        check("min_k1_again", {2'b00, ro2, busy2, done2}, 5'b00110);
        @(posedge clk); #1;
        check("min_release", {2'b00, ro2, busy2, done2},
              {3'b000, (ACK_LAT == 0) ? 2'b01 : 2'b10});
        @(posedge clk); #1;
        check("min_done", {2'b00, ro2, busy2, done2}, 5'b00001);
        sw2 = 1'b1;
        @(posedge clk); #1;
        sw2 = 1'b0;
        check("min_sw_restart", {2'b00, ro2, busy2, done2}, 5'b00110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
